// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer for the single-cycle LEGv8 datapath.
// Prioritises invalid-opcode and IRQ causes and handshakes Exc/ExcAck/ERet.
module exc_ctrl #(
  parameter int IRQ_W  = 4,
  parameter int ACK_TO = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             invalid_op,
  input  logic             eret_instr,
  input  logic [IRQ_W-1:0] irq,
  input  logic [IRQ_W-1:0] irq_mask,
  input  logic             ExcAck,
  output logic             Exc,
  output logic [3:0]       EStatus,
  output logic             ERet,
  output logic             busy,
  output logic             double_fault,
  output logic             ack_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HANDLER
  } state_t;

  state_t           state_q, state_d;
  logic [IRQ_W-1:0] pend_q, pend_d;
  logic [IRQ_W-1:0] prev_q;
  logic [IRQ_W-1:0] clr;
  logic [3:0]       es_q, es_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             df_q, df_d;
  logic             ato_q, ato_d;
  logic             irq_hit;
  logic [3:0]       irq_code;

  // Lowest enabled pending line wins: scan high to low, last hit sticks.
  always_comb begin
    irq_hit  = 1'b0;
    irq_code = 4'h0;
    for (int i = IRQ_W - 1; i >= 0; i--) begin
      if (pend_q[i] & irq_mask[i]) begin
        irq_hit  = 1'b1;
        irq_code = 4'(i + 2);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    es_d    = es_q;
    cnt_d   = cnt_q;
    df_d    = df_q;
    ato_d   = ato_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (invalid_op) begin
          state_d = REQ;
          es_d    = 4'h1;
          cnt_d   = 8'd0;
        end else if (irq_hit) begin
          state_d = REQ;
          es_d    = irq_code;
          cnt_d   = 8'd0;
        end
      end
      REQ: begin
        if (ExcAck) begin
          state_d = HANDLER;
          for (int i = 0; i < IRQ_W; i++) begin
            if (es_q == 4'(i + 2)) clr[i] = 1'b1;
          end
        end else if (cnt_q == 8'(ACK_TO - 1)) begin
          state_d = IDLE;
          ato_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HANDLER: begin
        if (eret_instr) begin
          state_d = IDLE;
        end else if (invalid_op) begin
          df_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new rising edge beats a same-cycle ack clear.
    pend_d = (pend_q & ~clr) | (irq & ~prev_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      prev_q  <= '0;
      es_q    <= 4'h0;
      cnt_q   <= 8'd0;
      df_q    <= 1'b0;
      ato_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      prev_q  <= irq;
      es_q    <= es_d;
      cnt_q   <= cnt_d;
      df_q    <= df_d;
      ato_q   <= ato_d;
    end
  end

  assign Exc          = (state_q == REQ);
  assign EStatus      = es_q;
  assign ERet         = eret_instr & (state_q == HANDLER);
  assign busy         = (state_q != IDLE);
  assign double_fault = df_q;
  assign ack_timeout  = ato_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: stimulus queues expected outputs per
// cycle, a negedge monitor pops and compares them.
module tb_exc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       invalid_op;
  logic       eret_instr;
  logic [3:0] irq;
  logic [3:0] irq_mask;
  logic       ExcAck;
  logic       Exc;
  logic [3:0] EStatus;
  logic       ERet;
  logic       busy;
  logic       double_fault;
  logic       ack_timeout;

  exc_ctrl #(
    .IRQ_W (4),
    .ACK_TO(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .invalid_op  (invalid_op),
    .eret_instr  (eret_instr),
    .irq         (irq),
    .irq_mask    (irq_mask),
    .ExcAck      (ExcAck),
    .Exc         (Exc),
    .EStatus     (EStatus),
    .ERet        (ERet),
    .busy        (busy),
    .double_fault(double_fault),
    .ack_timeout (ack_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       exc;
    logic [3:0] es;
    logic       eret;
    logic       busy;
    logic       df;
    logic       ato;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_vec++;
      if ({Exc, EStatus, ERet, busy, double_fault, ack_timeout} !==
          {e.exc, e.es, e.eret, e.busy, e.df, e.ato}) begin
        n_bad++;
        $display("FAIL %s: got exc=%b es=%h eret=%b busy=%b df=%b ato=%b, want exc=%b es=%h eret=%b busy=%b df=%b ato=%b",
                 e.nm, Exc, EStatus, ERet, busy, double_fault, ack_timeout,
                 e.exc, e.es, e.eret, e.busy, e.df, e.ato);
      end
    end
  end

  task automatic push(input string nm, input logic x, input logic [3:0] es,
                      input logic rt, input logic b, input logic d, input logic a);
    exp_t e;
    e.nm = nm; e.exc = x; e.es = es; e.eret = rt;
    e.busy = b; e.df = d; e.ato = a;
    sbq.push_back(e);
  endtask

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic v(input string nm, input logic iop, input logic er,
                   input logic [3:0] iv, input logic [3:0] mv, input logic ack,
                   input logic x, input logic [3:0] es, input logic rt,
                   input logic b, input logic d, input logic a);
    invalid_op = iop; eret_instr = er; irq = iv; irq_mask = mv; ExcAck = ack;
    push(nm, x, es, rt, b, d, a);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; invalid_op = 0; eret_instr = 0;
    irq = 4'h0; irq_mask = 4'h0; ExcAck = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    v("reset_state", 0,0,4'h0,4'h0,0, 0,4'h0,0,0,0,0);
    // invalid opcode round trip
    v("iop_idle",    1,0,4'h0,4'h0,0, 0,4'h0,0,0,0,0);
    v("iop_req",     0,0,4'h0,4'h0,1, 1,4'h1,0,1,0,0);
    v("iop_hnd",     0,0,4'h0,4'h0,0, 0,4'h1,0,1,0,0);
    v("iop_eret",    0,1,4'h0,4'h0,0, 0,4'h1,1,1,0,0);
    v("iop_back",    0,0,4'h0,4'h0,0, 0,4'h1,0,0,0,0);
    // two lines, line1 first then line2 without new edge
    v("irq_rise",    0,0,4'h6,4'hF,0, 0,4'h1,0,0,0,0);
    v("irq_pend",    0,0,4'h6,4'hF,0, 0,4'h1,0,0,0,0);
    v("irq_l1_req",  0,0,4'h6,4'hF,1, 1,4'h3,0,1,0,0);
    v("irq_l1_eret", 0,1,4'h6,4'hF,0, 0,4'h3,1,1,0,0);
    v("irq_l1_idle", 0,0,4'h6,4'hF,0, 0,4'h3,0,0,0,0);
    v("irq_l2_req",  0,0,4'h6,4'hF,1, 1,4'h4,0,1,0,0);
    v("irq_l2_eret", 0,1,4'h6,4'hF,0, 0,4'h4,1,1,0,0);
    v("irq_drop",    0,0,4'h0,4'hF,0, 0,4'h4,0,0,0,0);
    // masked pending held, then unmasked
    v("mask_rise",   0,0,4'h1,4'h0,0, 0,4'h4,0,0,0,0);
    for (int i = 0; i < 20; i++)
      v("mask_hold", 0,0,4'h1,4'h0,0, 0,4'h4,0,0,0,0);
    v("unmask",      0,0,4'h1,4'h1,0, 0,4'h4,0,0,0,0);
    // ack timeout after 8 REQ cycles, then retry
    for (int i = 0; i < 8; i++)
      v("to_req",    0,0,4'h1,4'h1,0, 1,4'h2,0,1,0,0);
    v("to_idle",     0,0,4'h1,4'h1,0, 0,4'h2,0,0,0,1);
    v("to_retry",    0,0,4'h1,4'h1,1, 1,4'h2,0,1,0,1);
    // double fault inside handler
    v("df_iop",      1,0,4'h1,4'h1,0, 0,4'h2,0,1,0,1);
    v("df_stay",     0,0,4'h1,4'h1,0, 0,4'h2,0,1,1,1);
    v("df_both",     1,1,4'h1,4'h1,0, 0,4'h2,1,1,1,1);
    v("eret_idle",   0,1,4'h0,4'h1,0, 0,4'h2,0,0,1,1);
    v("idle_quiet",  0,0,4'h0,4'h1,0, 0,4'h2,0,0,1,1);
    // reset asserted while in HANDLER
    v("pre_rst_iop", 1,0,4'h0,4'h1,0, 0,4'h2,0,0,1,1);
    v("pre_rst_req", 0,0,4'h0,4'h1,1, 1,4'h1,0,1,1,1);
    invalid_op = 0; eret_instr = 0; ExcAck = 0;
    reset = 1'b1;
    push("rst_async", 0,4'h0,0,0,0,0);
    @(posedge clk); #1;
    reset = 1'b0;
    v("post_rst",    0,0,4'h0,4'h1,0, 0,4'h0,0,0,0,0);

    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d queued, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
